// File: rtl/fsk_tx_sequencer.sv
// fsk_tx_sequencer: transmit-side controller for the FSK modulator.
// Accepts one 16-bit word on a valid/ready handshake. It then sends the
// framed bit stream (alternating preamble, start 0, 16 data bits MSB first,
// stop 1). Each bit lasts BAUD_DIV clock cycles.
// Ports:
//   clk, reset       system clock, asynchronous active-low reset
//   din, din_valid   payload word and its valid
//   din_ready        combinational, high only in IDLE
//   abort            synchronous cancel of the active frame
//   fsk_sel          tone select (1 = mark, 0 = space)
//   tx_en, busy      high for the whole frame
//   bit_strobe       pulse on the first cycle of each bit
//   frame_done       pulse on the first IDLE cycle after a completed frame
module fsk_tx_sequencer #(
  parameter int unsigned BAUD_DIV      = 16,
  parameter int unsigned PREAMBLE_BITS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  input  logic        abort,
  output logic        fsk_sel,
  output logic        tx_en,
  output logic        busy,
  output logic        bit_strobe,
  output logic        frame_done
);

  localparam int unsigned DATA_W = 16;
  localparam int unsigned BAUD_W = 16;
  localparam int unsigned CNT_W  = 8;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BAUD_DIV - 1);
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PREAMBLE_BITS - 1);
  localparam logic [CNT_W-1:0]  DATA_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [2:0] {IDLE, PREAMBLE, START, DATA, STOP} state_t;

  state_t              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [CNT_W-1:0]    bit_q, bit_d;
  logic                fsk_d, tx_en_d, strobe_d, done_d;
  logic                bit_end;

  assign din_ready = (state_q == IDLE);
  assign bit_end   = (baud_q == BAUD_LAST);
  // busy and tx_en cover exactly the same cycles, so they share one flop
  assign busy      = tx_en;

  // State register and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      shreg_q    <= '0;
      baud_q     <= '0;
      bit_q      <= '0;
      fsk_sel    <= 1'b0;
      tx_en      <= 1'b0;
      bit_strobe <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      fsk_sel    <= fsk_d;
      tx_en      <= tx_en_d;
      bit_strobe <= strobe_d;
      frame_done <= done_d;
    end
  end

  // Next state, counters, and output values for the next cycle
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    done_d   = 1'b0;
    fsk_d    = 1'b0;
    tx_en_d  = 1'b0;
    strobe_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (din_valid) begin
          state_d = PREAMBLE;
          shreg_d = din;
          baud_d  = '0;
          bit_d   = '0;
        end
      end
      default: begin
        baud_d = bit_end ? '0 : baud_q + BAUD_W'(1);
        if (bit_end) begin
          bit_d = bit_q + CNT_W'(1);
          case (state_q)
            PREAMBLE: begin
              if (bit_q == PRE_LAST) begin
                state_d = START;
                bit_d   = '0;
              end
            end
            START: begin
              state_d = DATA;
              bit_d   = '0;
            end
            DATA: begin
              shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
              if (bit_q == DATA_LAST) begin
                state_d = STOP;
                bit_d   = '0;
              end
            end
            STOP: begin
              state_d = IDLE;
              bit_d   = '0;
              done_d  = 1'b1;
            end
            default: ;
          endcase
        end
        // Abort overrides any bit boundary, including the last STOP cycle
        if (abort) begin
          state_d = IDLE;
          baud_d  = '0;
          bit_d   = '0;
          done_d  = 1'b0;
        end
      end
    endcase

    // Outputs are computed from the next state, so they align with that cycle
    tx_en_d  = (state_d != IDLE);
    strobe_d = tx_en_d && (baud_d == '0);
    unique case (state_d)
      PREAMBLE: fsk_d = ~bit_d[0];
      START:    fsk_d = 1'b0;
      DATA:     fsk_d = shreg_d[DATA_W-1];
      STOP:     fsk_d = 1'b1;
      default:  fsk_d = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_fsk_tx_sequencer.sv
module tb_fsk_tx_sequencer;

  localparam int P  = 8;
  localparam int B1 = 4;
  localparam int B2 = 2;

  logic        clk;
  logic        reset;
  logic [15:0] din;
  logic        din_valid;
  logic        abort;
  logic        sel2;

  logic ready1, fsk1, tx1, busy1, stb1, done1;
  logic ready2, fsk2, tx2, busy2, stb2, done2;
  logic o_ready, o_fsk, o_tx, o_busy, o_stb, o_done;

  int checks;
  int errors;

  fsk_tx_sequencer #(.BAUD_DIV(B1), .PREAMBLE_BITS(P)) u_dut (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid & ~sel2),
    .din_ready(ready1), .abort(abort), .fsk_sel(fsk1), .tx_en(tx1),
    .busy(busy1), .bit_strobe(stb1), .frame_done(done1)
  );

  fsk_tx_sequencer #(.BAUD_DIV(B2), .PREAMBLE_BITS(P)) u_dut2 (
    .clk(clk), .reset(reset), .din(din), .din_valid(din_valid & sel2),
    .din_ready(ready2), .abort(abort), .fsk_sel(fsk2), .tx_en(tx2),
    .busy(busy2), .bit_strobe(stb2), .frame_done(done2)
  );

  assign o_ready = sel2 ? ready2 : ready1;
  assign o_fsk   = sel2 ? fsk2   : fsk1;
  assign o_tx    = sel2 ? tx2    : tx1;
  assign o_busy  = sel2 ? busy2  : busy1;
  assign o_stb   = sel2 ? stb2   : stb1;
  assign o_done  = sel2 ? done2  : done1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: value of frame bit i for payload w
  function automatic logic exp_bit(input logic [15:0] w, input int i);
    if (i < P)            return ((i % 2) == 0) ? 1'b1 : 1'b0;
    else if (i == P)      return 1'b0;
    else if (i < P + 17)  return w[4'(15 - (i - P - 1))];
    else                  return 1'b1;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; din_valid = 1'b0; abort = 1'b0; din = '0; sel2 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({ready1, fsk1, tx1, busy1, stb1, done1} !== 6'b100000) begin
      errors++;
      $display("FAIL reset_state got %b exp 100000", {ready1, fsk1, tx1, busy1, stb1, done1});
    end
    reset = 1'b1;
    for (int n = 0; n < 50; n++) begin
      step();
      checks++;
      if ({ready1, fsk1, tx1, busy1, stb1, done1} !== 6'b100000 ||
          {ready2, fsk2, tx2, busy2, stb2, done2} !== 6'b100000) begin
        errors++;
        $display("FAIL idle_after_reset n=%0d got %b/%b exp 100000", n,
                 {ready1, fsk1, tx1, busy1, stb1, done1}, {ready2, fsk2, tx2, busy2, stb2, done2});
      end
    end
  endtask

  // One complete frame; optional din_valid glitch with 16'h1234 at cycle glitch
  task automatic test_frame(input logic [15:0] word, input logic use2, input int glitch);
    int b;
    int len;
    int strobes;
    int txc;
    b = use2 ? B2 : B1;
    len = (P + 18) * b;
    strobes = 0;
    txc = 0;
    sel2 = use2;
    din = word;
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    din = 16'($urandom);
    for (int n = 0; n < len; n++) begin
      if (n == glitch) begin
        din_valid = 1'b1;
        din = 16'h1234;
      end else begin
        din_valid = 1'b0;
      end
      checks++;
      if (o_tx !== 1'b1 || o_busy !== 1'b1 || o_ready !== 1'b0 || o_done !== 1'b0) begin
        errors++;
        $display("FAIL frame_ctrl n=%0d got tx=%b busy=%b ready=%b done=%b exp 1100", n, o_tx, o_busy, o_ready, o_done);
      end
      checks++;
      if (o_fsk !== exp_bit(word, n / b)) begin
        errors++;
        $display("FAIL fsk_sel word=%h n=%0d got %b exp %b", word, n, o_fsk, exp_bit(word, n / b));
      end
      checks++;
      if (o_stb !== (((n % b) == 0) ? 1'b1 : 1'b0)) begin
        errors++;
        $display("FAIL bit_strobe n=%0d got %b exp %b", n, o_stb, (n % b) == 0);
      end
      if (o_stb === 1'b1) strobes++;
      if (o_tx === 1'b1) txc++;
      step();
    end
    din_valid = 1'b0;
    checks++;
    if ({o_done, o_ready, o_tx, o_busy, o_fsk, o_stb} !== 6'b110000) begin
      errors++;
      $display("FAIL frame_done_cycle got %b exp 110000", {o_done, o_ready, o_tx, o_busy, o_fsk, o_stb});
    end
    checks++;
    if (strobes != P + 18 || txc != len) begin
      errors++;
      $display("FAIL frame_counts got strobes=%0d tx=%0d exp %0d %0d", strobes, txc, P + 18, len);
    end
    step();
    checks++;
    if (o_done !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL after_done got done=%b busy=%b exp 00", o_done, o_busy);
    end
    sel2 = 1'b0;
  endtask

  task automatic test_single_frame();
    test_frame(16'hA5C3, 1'b0, -1);
    for (int k = 0; k < 3; k++) begin
      repeat ($urandom_range(0, 5)) step();
      test_frame(16'($urandom), 1'b0, -1);
    end
  endtask

  task automatic test_back_to_back();
    int len;
    logic [15:0] w;
    len = (P + 18) * B1;
    din = 16'hFFFF;
    din_valid = 1'b1;
    step();
    din = 16'h0001;
    for (int f = 0; f < 2; f++) begin
      w = (f == 0) ? 16'hFFFF : 16'h0001;
      for (int n = 0; n < len; n++) begin
        if (f == 1) din_valid = 1'b0;
        checks++;
        if (o_tx !== 1'b1 || o_ready !== 1'b0 || o_fsk !== exp_bit(w, n / B1) ||
            o_stb !== (((n % B1) == 0) ? 1'b1 : 1'b0)) begin
          errors++;
          $display("FAIL b2b f=%0d n=%0d got tx=%b ready=%b fsk=%b stb=%b exp fsk=%b", f, n,
                   o_tx, o_ready, o_fsk, o_stb, exp_bit(w, n / B1));
        end
        step();
      end
      checks++;
      if ({o_done, o_ready, o_tx} !== 3'b110) begin
        errors++;
        $display("FAIL b2b_gap f=%0d got done/ready/tx=%b exp 110", f, {o_done, o_ready, o_tx});
      end
      step();
    end
    checks++;
    if (o_busy !== 1'b0 || o_done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_end got busy=%b done=%b exp 00", o_busy, o_done);
    end
  endtask

  task automatic test_handshake_ignore();
    // glitch lands mid-bit of data bit 6
    test_frame(16'($urandom), 1'b0, (P + 1 + 6) * B1 + 1);
  endtask

  task automatic test_abort();
    int at;
    int waited;
    logic seen;
    din = 16'($urandom);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    at = (P + 1 + 5) * B1 + int'($urandom_range(0, B1 - 1));
    for (int n = 0; n < at; n++) step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++;
    if ({o_tx, o_busy, o_fsk, o_stb, o_done, o_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL abort_idle got %b exp 000001", {o_tx, o_busy, o_fsk, o_stb, o_done, o_ready});
    end
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (o_done === 1'b1 || o_busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL abort_no_done got activity=%b exp 0", seen);
    end
    // abort together with din_valid in IDLE still accepts the word
    abort = 1'b1;
    din_valid = 1'b1;
    din = 16'($urandom);
    step();
    abort = 1'b0;
    din_valid = 1'b0;
    checks++;
    if ({o_busy, o_stb, o_fsk} !== 3'b111) begin
      errors++;
      $display("FAIL abort_accept got busy/stb/fsk=%b exp 111", {o_busy, o_stb, o_fsk});
    end
    waited = 1;
    while (o_done !== 1'b1 && waited < 300) begin
      step();
      waited++;
    end
    checks++;
    if (waited != (P + 18) * B1 + 1) begin
      errors++;
      $display("FAIL abort_accept_len got %0d exp %0d", waited, (P + 18) * B1 + 1);
    end
    step();
    test_frame(16'($urandom), 1'b0, -1);
  endtask

  task automatic test_reset_mid_stop();
    logic seen;
    din = 16'($urandom);
    din_valid = 1'b1;
    step();
    din_valid = 1'b0;
    for (int n = 0; n < (P + 17) * B1 + 1; n++) step();
    checks++;
    if (o_fsk !== 1'b1 || o_tx !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_stop got fsk=%b tx=%b exp 11", o_fsk, o_tx);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({o_fsk, o_tx, o_busy, o_stb, o_done, o_ready} !== 6'b000001) begin
      errors++;
      $display("FAIL async_reset got %b exp 000001", {o_fsk, o_tx, o_busy, o_stb, o_done, o_ready});
    end
    step();
    reset = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (o_done === 1'b1 || o_busy === 1'b1 || o_ready !== 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL reset_no_done got activity=%b exp 0", seen);
    end
    test_frame(16'hA5C3, 1'b1, -1);
    test_frame(16'($urandom), 1'b1, -1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_handshake_ignore();
    test_abort();
    test_reset_mid_stop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fsk_tx_sequencer.md
Name: fsk_tx_sequencer

Overview:
Transmit-side controller for the FSK modulator. It accepts one 16-bit payload word through a valid/ready handshake and holds it in an internal shift register. It then sequences a framed bit stream (preamble, start, data, stop), one bit per baud period. Its fsk_sel output drives the tone/frequency-word mux and tx_en gates the carrier.

Parameters:
BAUD_DIV, 16, clk cycles per transmitted bit; legal range 2..65535.
PREAMBLE_BITS, 8, number of alternating preamble bits; legal range 1..255.

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
din  input  16  payload word
din_valid  input  1  payload word present on din
din_ready  output  1  sequencer can accept a word (high only in IDLE)
abort  input  1  synchronous cancel of the frame in progress
fsk_sel  output  1  tone select: 1 = mark tone, 0 = space tone
tx_en  output  1  carrier enable, high for the whole frame
busy  output  1  high in any state other than IDLE
bit_strobe  output  1  one-cycle pulse on the first cycle of each transmitted bit
frame_done  output  1  one-cycle pulse when a frame completes normally

Behaviour:
- Reset (reset low, async):
  - state = IDLE; shift register, baud counter and bit counter = 0.
  - fsk_sel, tx_en, busy, bit_strobe and frame_done = 0.
  - din_ready is a combinational decode of state==IDLE. It reads 1 during reset, but no capture can occur while reset is low.
- States: IDLE, PREAMBLE, START, DATA, STOP.
- Acceptance:
  - Occurs on a rising edge with state==IDLE and din_valid=1.
  - din is latched into the shift register.
  - Next state = PREAMBLE; baud counter = 0; bit counter = 0.
  - din_valid with din_ready low is ignored; din is not sampled.
- Bit timing:
  - Each bit occupies exactly BAUD_DIV cycles.
  - The baud counter runs 0..BAUD_DIV-1 and wraps.
  - bit_strobe = 1 in the cycle where the baud counter is 0 and state != IDLE.
  - State and bit transitions happen on the edge where the baud counter is BAUD_DIV-1.
- Bit values (fsk_sel is registered and updates in the same cycle that bit_strobe is high):
  - PREAMBLE: PREAMBLE_BITS bits alternating, starting with 1 (1,0,1,0,...); then go to START.
  - START: one bit of 0; then go to DATA.
  - DATA: 16 bits, MSB first. The shift register shifts left on each bit boundary. After the 16th bit, go to STOP.
  - STOP: one bit of 1. On its last cycle, go to IDLE and set frame_done=1 for exactly one cycle (the first IDLE cycle).
- Frame length: (PREAMBLE_BITS+18)*BAUD_DIV cycles, from the first PREAMBLE cycle to the last STOP cycle.
- tx_en and busy:
  - Both are 1 from the first PREAMBLE cycle through the last STOP cycle.
  - Both are 0 in IDLE. fsk_sel is 0 in IDLE.
- Back-to-back frames: din_ready rises in the frame_done cycle. A word presented then is accepted on that edge, so PREAMBLE starts on the next cycle and there is exactly one IDLE cycle between frames.
- abort:
  - When sampled high with state != IDLE: next state = IDLE; tx_en, busy and fsk_sel = 0; counters cleared; no frame_done.
  - abort is ignored in IDLE.
  - If abort and din_valid are both high in IDLE, the word is accepted.
- Async reset mid-frame: immediate return to the reset values; no frame_done.
- No other inputs affect an active frame. din may change freely once the word has been accepted.

Test Plan:
- Reset then idle (BAUD_DIV=4, PREAMBLE_BITS=8): reset low for 3 cycles, then released, no din_valid -> all outputs 0, din_ready=1, no bit_strobe for 50 cycles.
- Single frame, din=16'hA5C3 accepted at cycle T:
  - fsk_sel per bit = 10101010, 0, 1010010111000011, 1; each bit lasts 4 cycles.
  - 26 bit_strobe pulses, tx_en high for 104 cycles, frame_done pulse at T+105.
- Back-to-back: din_valid held high with 16'hFFFF then 16'h0001 -> second acceptance on the frame_done edge, one IDLE cycle between frames, second data field = fifteen 0s then a 1.
- Handshake ignore: din_valid pulsed with 16'h1234 in the middle of a DATA bit -> frame data unchanged, no second frame started, din_ready stays 0 until frame_done.
- Abort: abort pulsed for 1 cycle during DATA bit 5 -> next cycle IDLE with tx_en=0, fsk_sel=0, no frame_done; a new word is accepted normally afterwards.
- Async reset mid-STOP bit: reset pulsed low for 1 cycle -> outputs 0 immediately, no frame_done, state IDLE; BAUD_DIV=2 rerun of the single-frame case gives a frame length of 52 cycles.
